// File: rtl/kernel_ctrl.sv
// -----------------------------------------------------------------------------
// kernel_ctrl
//
// Sequencer for the kernel row-buffer datapath. It parses the dtype marker
// stream (frame/row/pixel) with a three-state FSM, drives the shared row-buffer
// column address and write enable, tracks the row/column position, and flags
// each pixel that completes a full KERNEL_SIZE x KERNEL_SIZE window. Stream
// ordering problems and row-buffer overruns are reported on sticky flags.
//
// Ports
//   clk              in   system clock
//   reset            in   synchronous, active-high reset
//   enable           in   sampled at FRAME_START; 0 = ignore that frame
//   dvi              in   input data valid; nothing happens when low
//   dtypei           in   input data type (marker code or pixel type)
//   clear_err        in   clears both sticky error flags
//   col_addr         out  row-buffer column address (registered)
//   we               out  row-buffer write enable (combinational)
//   row_count        out  completed rows in the current frame, saturating
//   kernel_valid     out  1-cycle pulse, previous pixel completed a window
//   frame_active     out  FSM is not in IDLE
//   num_cols         out  pixel count of the last completed row, saturating
//   num_rows         out  row count latched when the frame ended
//   err_col_overflow out  sticky: pixel arrived at col >= MAX_COLS
//   err_protocol     out  sticky: marker arrived out of order
// -----------------------------------------------------------------------------
module kernel_ctrl #(
  parameter int KERNEL_SIZE    = 3,
  parameter int MAX_COLS       = 1288,
  parameter int NUM_COLS_WIDTH = 11,
  parameter int NUM_ROWS_WIDTH = 11,
  parameter int DTYPE_WIDTH    = 8,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 8'h01,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 8'h02,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 8'h04,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 8'h08,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 8'h10,
  parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 8'hE0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      dvi,
  input  logic [DTYPE_WIDTH-1:0]    dtypei,
  input  logic                      clear_err,
  output logic [NUM_COLS_WIDTH-1:0] col_addr,
  output logic                      we,
  output logic [NUM_ROWS_WIDTH-1:0] row_count,
  output logic                      kernel_valid,
  output logic                      frame_active,
  output logic [NUM_COLS_WIDTH-1:0] num_cols,
  output logic [NUM_ROWS_WIDTH-1:0] num_rows,
  output logic                      err_col_overflow,
  output logic                      err_protocol
);

  // Rows/columns that cannot be the bottom-right corner of a full window.
  localparam int BORDER = KERNEL_SIZE - 1;

  localparam logic [NUM_COLS_WIDTH-1:0] COL_BORDER = NUM_COLS_WIDTH'(BORDER);
  localparam logic [NUM_ROWS_WIDTH-1:0] ROW_BORDER = NUM_ROWS_WIDTH'(BORDER);
  localparam logic [NUM_COLS_WIDTH-1:0] COL_LIMIT  = NUM_COLS_WIDTH'(MAX_COLS);
  localparam logic [NUM_COLS_WIDTH-1:0] COL_SAT    = {NUM_COLS_WIDTH{1'b1}};
  localparam logic [NUM_ROWS_WIDTH-1:0] ROW_SAT    = {NUM_ROWS_WIDTH{1'b1}};
  localparam logic [NUM_COLS_WIDTH-1:0] COL_ONE    = NUM_COLS_WIDTH'(1);
  localparam logic [NUM_ROWS_WIDTH-1:0] ROW_ONE    = NUM_ROWS_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_ROW   = 2'd2
  } state_t;

  state_t                      state_r, state_s;
  logic [NUM_COLS_WIDTH-1:0]   col_addr_r, col_addr_s;
  logic [NUM_ROWS_WIDTH-1:0]   row_count_r, row_count_s;
  logic [NUM_COLS_WIDTH-1:0]   num_cols_r, num_cols_s;
  logic [NUM_ROWS_WIDTH-1:0]   num_rows_r, num_rows_s;
  logic                        kernel_valid_r, kernel_valid_s;
  logic                        err_col_r, err_col_s;
  logic                        err_proto_r, err_proto_s;

  // Decoded events; all are qualified by dvi so idle cycles hold state.
  logic pix_s;
  logic is_fs_s;
  logic is_fe_s;
  logic is_rs_s;
  logic is_re_s;
  logic col_in_range_s;
  logic proto_set_s;
  logic ovf_set_s;

  // Saturating increments shared by the next-state logic.
  function automatic logic [NUM_COLS_WIDTH-1:0] col_inc_sat(input logic [NUM_COLS_WIDTH-1:0] v);
    if (v == COL_SAT) begin
      col_inc_sat = COL_SAT;
    end else begin
      col_inc_sat = v + COL_ONE;
    end
  endfunction

  function automatic logic [NUM_ROWS_WIDTH-1:0] row_inc_sat(input logic [NUM_ROWS_WIDTH-1:0] v);
    if (v == ROW_SAT) begin
      row_inc_sat = ROW_SAT;
    end else begin
      row_inc_sat = v + ROW_ONE;
    end
  endfunction

  // Event decode from the dtype stream.
  always_comb begin
    pix_s          = dvi & (|(dtypei & DTYPE_PIXEL_MASK));
    is_fs_s        = dvi & (dtypei == DTYPE_FRAME_START);
    is_fe_s        = dvi & (dtypei == DTYPE_FRAME_END);
    is_rs_s        = dvi & (dtypei == DTYPE_ROW_START);
    is_re_s        = dvi & (dtypei == DTYPE_ROW_END);
    col_in_range_s = (col_addr_r < COL_LIMIT);
  end

  // Next-state, counter and flag logic for the marker FSM.
  always_comb begin
    state_s        = state_r;
    col_addr_s     = col_addr_r;
    row_count_s    = row_count_r;
    num_cols_s     = num_cols_r;
    num_rows_s     = num_rows_r;
    kernel_valid_s = 1'b0;
    proto_set_s    = 1'b0;
    ovf_set_s      = 1'b0;

    if (is_fs_s) begin
      // FRAME_START restarts the frame from any state; a row cut short is an error.
      row_count_s = '0;
      if (enable) begin
        state_s = S_FRAME;
      end else begin
        state_s = S_IDLE;
      end
      if (state_r == S_ROW) begin
        proto_set_s = 1'b1;
      end else begin
        proto_set_s = 1'b0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (is_rs_s || is_re_s || pix_s) begin
            proto_set_s = 1'b1;
          end else begin
            proto_set_s = 1'b0;
          end
        end
        S_FRAME: begin
          if (is_rs_s) begin
            state_s    = S_ROW;
            col_addr_s = '0;
          end else if (is_fe_s) begin
            state_s    = S_IDLE;
            num_rows_s = row_count_r;
          end else if (pix_s || is_re_s) begin
            proto_set_s = 1'b1;
          end else begin
            proto_set_s = 1'b0;
          end
        end
        S_ROW: begin
          if (pix_s) begin
            // Address keeps counting past the buffer so num_cols reports the true width.
            col_addr_s     = col_inc_sat(col_addr_r);
            ovf_set_s      = ~col_in_range_s;
            kernel_valid_s = (row_count_r >= ROW_BORDER) &
                             (col_addr_r >= COL_BORDER) & col_in_range_s;
          end else if (is_re_s) begin
            state_s     = S_FRAME;
            row_count_s = row_inc_sat(row_count_r);
            num_cols_s  = col_addr_r;
          end else if (is_rs_s) begin
            // Row restarted without ROW_END: rewind, keep the row count.
            proto_set_s = 1'b1;
            col_addr_s  = '0;
          end else if (is_fe_s) begin
            proto_set_s = 1'b1;
            state_s     = S_IDLE;
            num_rows_s  = row_count_r;
          end else begin
            proto_set_s = 1'b0;
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end

    // Sticky flags: a new error in the same cycle as clear_err wins.
    if (proto_set_s) begin
      err_proto_s = 1'b1;
    end else if (clear_err) begin
      err_proto_s = 1'b0;
    end else begin
      err_proto_s = err_proto_r;
    end

    if (ovf_set_s) begin
      err_col_s = 1'b1;
    end else if (clear_err) begin
      err_col_s = 1'b0;
    end else begin
      err_col_s = err_col_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_IDLE;
      col_addr_r     <= '0;
      row_count_r    <= '0;
      num_cols_r     <= '0;
      num_rows_r     <= '0;
      kernel_valid_r <= 1'b0;
      err_col_r      <= 1'b0;
      err_proto_r    <= 1'b0;
    end else begin
      state_r        <= state_s;
      col_addr_r     <= col_addr_s;
      row_count_r    <= row_count_s;
      num_cols_r     <= num_cols_s;
      num_rows_r     <= num_rows_s;
      kernel_valid_r <= kernel_valid_s;
      err_col_r      <= err_col_s;
      err_proto_r    <= err_proto_s;
    end
  end

  // Write uses the pre-increment address so it lines up with the pixel itself.
  assign we               = pix_s & (state_r == S_ROW) & col_in_range_s;
  assign col_addr         = col_addr_r;
  assign row_count        = row_count_r;
  assign kernel_valid     = kernel_valid_r;
  assign frame_active     = (state_r != S_IDLE);
  assign num_cols         = num_cols_r;
  assign num_rows         = num_rows_r;
  assign err_col_overflow = err_col_r;
  assign err_protocol     = err_proto_r;

endmodule
